// File: rtl/traffic_light_pkg.sv
// Shared state encoding and light-head constants for the intersection controller.
package traffic_light_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED2  = 3'd5,
    FLASH     = 3'd6
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  // Returns {ns_light, ew_light} shown while in state s.
  function automatic logic [5:0] headLights(state_t s, logic flashOn);
    logic [5:0] heads;
    heads = {RED, RED};
    case (s)
      NS_GREEN:  heads = {GRN, RED};
      NS_YELLOW: heads = {YEL, RED};
      ALL_RED1:  heads = {RED, RED};
      EW_GREEN:  heads = {RED, GRN};
      EW_YELLOW: heads = {RED, YEL};
      ALL_RED2:  heads = {RED, RED};
      FLASH:     heads = flashOn ? {YEL, YEL} : {OFF, OFF};
      default:   heads = {RED, RED};
    endcase
    return heads;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// Free-running prescaler: o_tick is high for the one cycle the count sits at CLK_DIV-1.
module tick_gen #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_pre;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (r_pre == LAST) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  assign o_tick = (r_pre == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection sequencer: NS main road rests in green, EW served on demand,
// with a maintenance flash override. All outputs come straight from registers.
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int CLK_DIV  = 50_000_000,
  parameter int GREEN_T  = 30,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sensor_ew,
  input  logic          ped_req,
  input  logic          maint_flash,
  output logic [2:0]    ns_light,
  output logic [2:0]    ew_light,
  output logic          ped_walk,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] GREEN_LD  = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] YELLOW_LD = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] ALLRED_LD = CW'(ALLRED_T - 1);

  logic          w_tick;
  state_t        r_state, w_nextState;
  logic [CW-1:0] r_count, w_nextCount;
  logic          r_pending, w_nextPending;
  logic          r_pedLatched, w_nextPedLatched;
  logic          r_flashOn, w_nextFlashOn;
  logic          r_walk, w_nextWalk;
  logic          w_enterEw;
  logic [2:0]    r_ns, r_ew;
  logic [5:0]    w_heads;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ALL_RED2;
      r_count      <= ALLRED_LD;
      r_pending    <= 1'b0;
      r_pedLatched <= 1'b0;
      r_flashOn    <= 1'b0;
      r_walk       <= 1'b0;
      r_ns         <= RED;
      r_ew         <= RED;
    end else begin
      r_state      <= w_nextState;
      r_count      <= w_nextCount;
      r_pending    <= w_nextPending;
      r_pedLatched <= w_nextPedLatched;
      r_flashOn    <= w_nextFlashOn;
      r_walk       <= w_nextWalk;
      r_ns         <= w_heads[5:3];
      r_ew         <= w_heads[2:0];
    end
  end

  // Flash override wins over everything; otherwise phases only advance on a tick
  // that finds the timer already at zero. NS green rests there until a request exists.
  always_comb begin
    w_nextState   = r_state;
    w_nextCount   = r_count;
    w_nextFlashOn = r_flashOn;
    w_enterEw     = 1'b0;
    if (maint_flash) begin
      w_nextState   = FLASH;
      w_nextCount   = '0;
      w_nextFlashOn = (r_state == FLASH) ? (r_flashOn ^ w_tick) : 1'b1;
    end else if (r_state == FLASH) begin
      w_nextState = ALL_RED2;
      w_nextCount = ALLRED_LD;
    end else if (w_tick) begin
      if (r_count != '0) begin
        w_nextCount = r_count - CW'(1);
      end else begin
        case (r_state)
          NS_GREEN: begin
            if (r_pending) begin
              w_nextState = NS_YELLOW;
              w_nextCount = YELLOW_LD;
            end
          end
          NS_YELLOW: begin
            w_nextState = ALL_RED1;
            w_nextCount = ALLRED_LD;
          end
          ALL_RED1: begin
            w_nextState = EW_GREEN;
            w_nextCount = GREEN_LD;
            w_enterEw   = 1'b1;
          end
          EW_GREEN: begin
            w_nextState = EW_YELLOW;
            w_nextCount = YELLOW_LD;
          end
          EW_YELLOW: begin
            w_nextState = ALL_RED2;
            w_nextCount = ALLRED_LD;
          end
          ALL_RED2: begin
            w_nextState = NS_GREEN;
            w_nextCount = GREEN_LD;
          end
          default: begin
            w_nextState = ALL_RED2;
            w_nextCount = ALLRED_LD;
          end
        endcase
      end
    end

    // Clearing on EW entry takes priority over a request arriving in that same cycle.
    w_nextPending    = w_enterEw ? 1'b0 : (r_pending | sensor_ew | ped_req);
    w_nextPedLatched = w_enterEw ? 1'b0 : (r_pedLatched | ped_req);
    w_nextWalk       = (w_nextState == EW_GREEN) && (w_enterEw ? r_pedLatched : r_walk);
    w_heads          = headLights(w_nextState, w_nextFlashOn);
  end

  assign ns_light = r_ns;
  assign ew_light = r_ew;
  assign ped_walk = r_walk;
  assign count    = r_count;

endmodule
